// File: rtl/rob_enq_commit.sv
// Reorder buffer: dual in-order enqueue from dispatch,
// writeback completion marking, dual in-order commit.
module rob_enq_commit #(
   parameter int ROB_SIZE_LOG = 6,
   parameter int PREG_W       = 6,
   parameter int LREG_W       = 5,
   parameter int PC_W         = 64
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    flush,
   input  logic                    instr0_enq_valid,
   input  logic [PC_W-1:0]         instr0_pc,
   input  logic [LREG_W-1:0]       instr0_lrd,
   input  logic [PREG_W-1:0]       instr0_prd,
   input  logic [PREG_W-1:0]       instr0_old_prd,
   input  logic                    instr0_need_to_wb,
   input  logic                    instr1_enq_valid,
   input  logic [PC_W-1:0]         instr1_pc,
   input  logic [LREG_W-1:0]       instr1_lrd,
   input  logic [PREG_W-1:0]       instr1_prd,
   input  logic [PREG_W-1:0]       instr1_old_prd,
   input  logic                    instr1_need_to_wb,
   output logic                    enq_ready,
   output logic [ROB_SIZE_LOG:0]   counter,
   output logic                    enq_robidx_flag,
   output logic [ROB_SIZE_LOG-1:0] enq_robidx,
   input  logic                    wb0_valid,
   input  logic [ROB_SIZE_LOG-1:0] wb0_robidx,
   input  logic                    wb1_valid,
   input  logic [ROB_SIZE_LOG-1:0] wb1_robidx,
   output logic                    commit0_valid,
   output logic [PC_W-1:0]         commit0_pc,
   output logic [LREG_W-1:0]       commit0_lrd,
   output logic [PREG_W-1:0]       commit0_prd,
   output logic [PREG_W-1:0]       commit0_old_prd,
   output logic                    commit0_need_to_wb,
   output logic                    commit1_valid,
   output logic [PC_W-1:0]         commit1_pc,
   output logic [LREG_W-1:0]       commit1_lrd,
   output logic [PREG_W-1:0]       commit1_prd,
   output logic [PREG_W-1:0]       commit1_old_prd,
   output logic                    commit1_need_to_wb
);

   localparam int SIZE = 1 << ROB_SIZE_LOG;
   localparam int CW   = ROB_SIZE_LOG + 1;
   localparam int IW   = ROB_SIZE_LOG;

   typedef struct packed {
      logic [PC_W-1:0]   pc;
      logic [LREG_W-1:0] lrd;
      logic [PREG_W-1:0] prd;
      logic [PREG_W-1:0] old_prd;
      logic              nwb;
   } entry_t;

   entry_t          ent_q [SIZE];
   entry_t          ent_d [SIZE];
   logic [SIZE-1:0] cmp_q, cmp_d;
   logic [CW-1:0]   head_q, head_d;
   logic [CW-1:0]   tail_q, tail_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [IW-1:0]   hidx, hidx1;
   logic [IW-1:0]   tidx, tidx1;
   logic            enq0, enq1;
   logic            com0, com1;

   assign hidx  = head_q[IW-1:0];
   assign hidx1 = hidx + IW'(1);
   assign tidx  = tail_q[IW-1:0];
   assign tidx1 = tidx + IW'(1);

   assign enq_ready       = cnt_q <= CW'(SIZE - 2);
   assign counter         = cnt_q;
   assign enq_robidx      = tidx;
   assign enq_robidx_flag = tail_q[IW];

   // instr1 rides only alongside instr0; flush blocks both
   assign enq0 = enq_ready & instr0_enq_valid & ~flush;
   assign enq1 = enq0 & instr1_enq_valid;

   // retire from head while the oldest entries are complete
   assign com0 = ~flush & (cnt_q != '0) & cmp_q[hidx];
   assign com1 = com0 & (cnt_q >= CW'(2)) & cmp_q[hidx1];

   assign commit0_valid      = com0;
   assign commit0_pc         = ent_q[hidx].pc;
   assign commit0_lrd        = ent_q[hidx].lrd;
   assign commit0_prd        = ent_q[hidx].prd;
   assign commit0_old_prd    = ent_q[hidx].old_prd;
   assign commit0_need_to_wb = ent_q[hidx].nwb;
   assign commit1_valid      = com1;
   assign commit1_pc         = ent_q[hidx1].pc;
   assign commit1_lrd        = ent_q[hidx1].lrd;
   assign commit1_prd        = ent_q[hidx1].prd;
   assign commit1_old_prd    = ent_q[hidx1].old_prd;
   assign commit1_need_to_wb = ent_q[hidx1].nwb;

   // payload write for newly allocated entries
   always_comb begin
      ent_d = ent_q;
      if (enq0) begin
         ent_d[tidx] = '{pc: instr0_pc, lrd: instr0_lrd,
                         prd: instr0_prd,
                         old_prd: instr0_old_prd,
                         nwb: instr0_need_to_wb};
      end
      if (enq1) begin
         ent_d[tidx1] = '{pc: instr1_pc, lrd: instr1_lrd,
                          prd: instr1_prd,
                          old_prd: instr1_old_prd,
                          nwb: instr1_need_to_wb};
      end
   end

   // complete bits: clear on commit, set on wb, clear on alloc
   always_comb begin
      cmp_d = cmp_q;
      if (com0) cmp_d[hidx] = 1'b0;
      if (com1) cmp_d[hidx1] = 1'b0;
      if (wb0_valid) cmp_d[wb0_robidx] = 1'b1;
      if (wb1_valid) cmp_d[wb1_robidx] = 1'b1;
      if (enq0) cmp_d[tidx] = 1'b0;
      if (enq1) cmp_d[tidx1] = 1'b0;
      if (flush) cmp_d = '0;
   end

   // pointer and occupancy update
   always_comb begin
      head_d = head_q + CW'(com0) + CW'(com1);
      tail_d = tail_q + CW'(enq0) + CW'(enq1);
      cnt_d  = cnt_q + CW'(enq0) + CW'(enq1)
             - CW'(com0) - CW'(com1);
      if (flush) begin
         head_d = '0;
         tail_d = '0;
         cnt_d  = '0;
      end
   end

   // payload storage needs no reset: complete bits gate use
   always_ff @(posedge clock) begin
      ent_q <= ent_d;
   end

   // control state with asynchronous clear
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cmp_q  <= '0;
         head_q <= '0;
         tail_q <= '0;
         cnt_q  <= '0;
      end else begin
         cmp_q  <= cmp_d;
         head_q <= head_d;
         tail_q <= tail_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule

// File: tb/tb_rob_enq_commit.sv
// Directed self-checking bench for rob_enq_commit.
// Each task drives one scenario and checks inline.
module tb_rob_enq_commit;

   logic        clock, reset_n, flush;
   logic        instr0_enq_valid, instr1_enq_valid;
   logic [63:0] instr0_pc, instr1_pc;
   logic [4:0]  instr0_lrd, instr1_lrd;
   logic [5:0]  instr0_prd, instr1_prd;
   logic [5:0]  instr0_old_prd, instr1_old_prd;
   logic        instr0_need_to_wb, instr1_need_to_wb;
   logic        enq_ready, enq_robidx_flag;
   logic [6:0]  counter;
   logic [5:0]  enq_robidx;
   logic        wb0_valid, wb1_valid;
   logic [5:0]  wb0_robidx, wb1_robidx;
   logic        commit0_valid, commit1_valid;
   logic [63:0] commit0_pc, commit1_pc;
   logic [4:0]  commit0_lrd, commit1_lrd;
   logic [5:0]  commit0_prd, commit1_prd;
   logic [5:0]  commit0_old_prd, commit1_old_prd;
   logic        commit0_need_to_wb, commit1_need_to_wb;

   int checks = 0;
   int errors = 0;
   int tb_tail = 0;

   rob_enq_commit dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .instr0_enq_valid(instr0_enq_valid),
      .instr0_pc(instr0_pc), .instr0_lrd(instr0_lrd),
      .instr0_prd(instr0_prd),
      .instr0_old_prd(instr0_old_prd),
      .instr0_need_to_wb(instr0_need_to_wb),
      .instr1_enq_valid(instr1_enq_valid),
      .instr1_pc(instr1_pc), .instr1_lrd(instr1_lrd),
      .instr1_prd(instr1_prd),
      .instr1_old_prd(instr1_old_prd),
      .instr1_need_to_wb(instr1_need_to_wb),
      .enq_ready(enq_ready), .counter(counter),
      .enq_robidx_flag(enq_robidx_flag),
      .enq_robidx(enq_robidx),
      .wb0_valid(wb0_valid), .wb0_robidx(wb0_robidx),
      .wb1_valid(wb1_valid), .wb1_robidx(wb1_robidx),
      .commit0_valid(commit0_valid),
      .commit0_pc(commit0_pc), .commit0_lrd(commit0_lrd),
      .commit0_prd(commit0_prd),
      .commit0_old_prd(commit0_old_prd),
      .commit0_need_to_wb(commit0_need_to_wb),
      .commit1_valid(commit1_valid),
      .commit1_pc(commit1_pc), .commit1_lrd(commit1_lrd),
      .commit1_prd(commit1_prd),
      .commit1_old_prd(commit1_old_prd),
      .commit1_need_to_wb(commit1_need_to_wb)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic logic [5:0] prd_of(int i);
      return 6'((i + 10) % 64);
   endfunction

   function automatic logic [63:0] pc_of(int i);
      return 64'h1000 + 64'(i * 4);
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic clr_in();
      flush = 0;
      instr0_enq_valid = 0; instr1_enq_valid = 0;
      instr0_pc = '0; instr0_lrd = '0; instr0_prd = '0;
      instr0_old_prd = '0; instr0_need_to_wb = 0;
      instr1_pc = '0; instr1_lrd = '0; instr1_prd = '0;
      instr1_old_prd = '0; instr1_need_to_wb = 0;
      wb0_valid = 0; wb0_robidx = '0;
      wb1_valid = 0; wb1_robidx = '0;
   endtask

   task automatic do_reset();
      clr_in();
      reset_n = 0;
      step();
      step();
      reset_n = 1;
      tb_tail = 0;
      #1;
   endtask

   // one enqueue cycle: instr0 always, instr1 when v1
   task automatic enq_cycle(input bit v1);
      int t1;
      t1 = (tb_tail + 1) % 64;
      instr0_enq_valid = 1;
      instr0_pc = pc_of(tb_tail);
      instr0_lrd = 5'(tb_tail % 32);
      instr0_prd = prd_of(tb_tail);
      instr0_old_prd = 6'((tb_tail + 33) % 64);
      instr0_need_to_wb = 1'(tb_tail % 2);
      instr1_enq_valid = v1;
      instr1_pc = pc_of(t1);
      instr1_lrd = 5'(t1 % 32);
      instr1_prd = prd_of(t1);
      instr1_old_prd = 6'((t1 + 33) % 64);
      instr1_need_to_wb = 1'(t1 % 2);
      step();
      instr0_enq_valid = 0;
      instr1_enq_valid = 0;
      tb_tail = (tb_tail + 1 + int'(v1)) % 64;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (counter !== 7'd0) begin errors++;
         $display("FAIL rst_cnt got %0d want 0", counter); end
      checks++; if (enq_robidx !== 6'd0) begin errors++;
         $display("FAIL rst_idx got %0d want 0", enq_robidx); end
      checks++; if (enq_robidx_flag !== 1'b0) begin errors++;
         $display("FAIL rst_flag got %b want 0", enq_robidx_flag); end
      checks++; if (enq_ready !== 1'b1) begin errors++;
         $display("FAIL rst_rdy got %b want 1", enq_ready); end
      checks++; if ({commit0_valid, commit1_valid} !== 2'b00) begin
         errors++;
         $display("FAIL rst_cv got %b%b want 00",
                  commit0_valid, commit1_valid); end
   endtask

   task automatic test_fill();
      do_reset();
      repeat (31) enq_cycle(1'b1);
      checks++; if (counter !== 7'd62) begin errors++;
         $display("FAIL fill62_cnt got %0d want 62", counter); end
      checks++; if (enq_ready !== 1'b1) begin errors++;
         $display("FAIL fill62_rdy got %b want 1", enq_ready); end
      enq_cycle(1'b1);
      checks++; if (counter !== 7'd64) begin errors++;
         $display("FAIL full_cnt got %0d want 64", counter); end
      checks++; if (enq_ready !== 1'b0) begin errors++;
         $display("FAIL full_rdy got %b want 0", enq_ready); end
      checks++; if (enq_robidx !== 6'd0) begin errors++;
         $display("FAIL full_idx got %0d want 0", enq_robidx); end
      checks++; if (enq_robidx_flag !== 1'b1) begin errors++;
         $display("FAIL full_flag got %b want 1", enq_robidx_flag); end
      instr0_enq_valid = 1;
      instr1_enq_valid = 1;
      step();
      clr_in();
      #1;
      checks++; if (counter !== 7'd64) begin errors++;
         $display("FAIL full_hold got %0d want 64", counter); end
      checks++; if (commit0_valid !== 1'b0) begin errors++;
         $display("FAIL full_cv got %b want 0", commit0_valid); end
   endtask

   task automatic test_drop();
      do_reset();
      instr1_enq_valid = 1;
      step();
      clr_in();
      #1;
      checks++; if (counter !== 7'd0) begin errors++;
         $display("FAIL drop_cnt got %0d want 0", counter); end
      checks++; if (enq_robidx !== 6'd0) begin errors++;
         $display("FAIL drop_idx got %0d want 0", enq_robidx); end
   endtask

   task automatic test_commit();
      do_reset();
      enq_cycle(1'b1);
      enq_cycle(1'b1);
      wb0_valid = 1; wb0_robidx = 6'd1;
      step();
      wb0_valid = 0;
      #1;
      checks++; if (commit0_valid !== 1'b0) begin errors++;
         $display("FAIL cm_wait got %b want 0", commit0_valid); end
      wb0_valid = 1; wb0_robidx = 6'd0;
      #1;
      checks++; if (commit0_valid !== 1'b0) begin errors++;
         $display("FAIL cm_same got %b want 0", commit0_valid); end
      step();
      wb0_valid = 0;
      #1;
      checks++; if (commit0_valid !== 1'b1) begin errors++;
         $display("FAIL cm_v0 got %b want 1", commit0_valid); end
      checks++; if (commit0_prd !== 6'd10) begin errors++;
         $display("FAIL cm_prd0 got %0d want 10", commit0_prd); end
      checks++; if (commit0_pc !== 64'h1000) begin errors++;
         $display("FAIL cm_pc0 got %h want 1000", commit0_pc); end
      checks++; if (commit1_valid !== 1'b1) begin errors++;
         $display("FAIL cm_v1 got %b want 1", commit1_valid); end
      checks++; if (commit1_prd !== 6'd11) begin errors++;
         $display("FAIL cm_prd1 got %0d want 11", commit1_prd); end
      checks++; if (commit1_old_prd !== 6'd34) begin errors++;
         $display("FAIL cm_old1 got %0d want 34", commit1_old_prd); end
      checks++; if (commit1_need_to_wb !== 1'b1) begin errors++;
         $display("FAIL cm_nwb1 got %b want 1", commit1_need_to_wb); end
      step();
      checks++; if (counter !== 7'd2) begin errors++;
         $display("FAIL cm_cnt got %0d want 2", counter); end
      checks++; if (commit0_valid !== 1'b0) begin errors++;
         $display("FAIL cm_after got %b want 0", commit0_valid); end
   endtask

   // relies on state left by test_commit: head=2, tail=4
   task automatic test_back_to_back();
      repeat (4) enq_cycle(1'b1);
      checks++; if (counter !== 7'd10) begin errors++;
         $display("FAIL b2b_pre got %0d want 10", counter); end
      wb0_valid = 1; wb0_robidx = 6'd2;
      wb1_valid = 1; wb1_robidx = 6'd3;
      step();
      wb0_valid = 0; wb1_valid = 0;
      #1;
      checks++; if ({commit0_valid, commit1_valid} !== 2'b11) begin
         errors++;
         $display("FAIL b2b_cv got %b%b want 11",
                  commit0_valid, commit1_valid); end
      checks++; if ({commit0_prd, commit1_prd} !== {6'd12, 6'd13})
      begin errors++;
         $display("FAIL b2b_prd got %0d,%0d want 12,13",
                  commit0_prd, commit1_prd); end
      enq_cycle(1'b1);
      checks++; if (counter !== 7'd10) begin errors++;
         $display("FAIL b2b_cnt got %0d want 10", counter); end
      checks++; if (enq_robidx !== 6'd14) begin errors++;
         $display("FAIL b2b_tail got %0d want 14", enq_robidx); end
      wb0_valid = 1; wb0_robidx = 6'd4;
      step();
      wb0_valid = 0;
      #1;
      checks++; if (commit0_valid !== 1'b1 || commit0_prd !== 6'd14)
      begin errors++;
         $display("FAIL b2b_head got v=%b prd=%0d want v=1 prd=14",
                  commit0_valid, commit0_prd); end
      checks++; if (commit1_valid !== 1'b0) begin errors++;
         $display("FAIL b2b_v1 got %b want 0", commit1_valid); end
   endtask

   task automatic test_wrap();
      do_reset();
      repeat (31) enq_cycle(1'b1);
      for (int k = 0; k < 31; k++) begin
         wb0_valid = 1; wb0_robidx = 6'(2 * k);
         wb1_valid = 1; wb1_robidx = 6'(2 * k + 1);
         step();
      end
      wb0_valid = 0; wb1_valid = 0;
      step();
      checks++; if (counter !== 7'd0) begin errors++;
         $display("FAIL wr_drain got %0d want 0", counter); end
      enq_cycle(1'b0);
      checks++; if (enq_robidx !== 6'd63 || enq_robidx_flag !== 1'b0)
      begin errors++;
         $display("FAIL wr_t63 got %0d/%b want 63/0",
                  enq_robidx, enq_robidx_flag); end
      enq_cycle(1'b1);
      checks++; if (enq_robidx !== 6'd1 || enq_robidx_flag !== 1'b1)
      begin errors++;
         $display("FAIL wr_t1 got %0d/%b want 1/1",
                  enq_robidx, enq_robidx_flag); end
      wb0_valid = 1; wb0_robidx = 6'd62;
      wb1_valid = 1; wb1_robidx = 6'd63;
      step();
      wb0_valid = 0; wb1_valid = 0;
      #1;
      checks++; if ({commit0_valid, commit1_valid} !== 2'b11 ||
                    commit0_prd !== prd_of(62) ||
                    commit1_prd !== prd_of(63)) begin errors++;
         $display("FAIL wr_c6263 got %b%b %0d,%0d want 11 %0d,%0d",
                  commit0_valid, commit1_valid, commit0_prd,
                  commit1_prd, prd_of(62), prd_of(63)); end
      wb0_valid = 1; wb0_robidx = 6'd0;
      step();
      wb0_valid = 0;
      #1;
      checks++; if (commit0_valid !== 1'b1 ||
                    commit0_prd !== 6'd10 ||
                    commit0_pc !== 64'h1000) begin errors++;
         $display("FAIL wr_c0 got %b %0d %h want 1 10 1000",
                  commit0_valid, commit0_prd, commit0_pc); end
      step();
      checks++; if (counter !== 7'd0) begin errors++;
         $display("FAIL wr_end got %0d want 0", counter); end
   endtask

   task automatic test_flush();
      do_reset();
      repeat (3) enq_cycle(1'b1);
      enq_cycle(1'b0);
      wb0_valid = 1; wb0_robidx = 6'd0;
      step();
      wb0_valid = 0;
      checks++; if (counter !== 7'd7) begin errors++;
         $display("FAIL fl_pre got %0d want 7", counter); end
      flush = 1;
      instr0_enq_valid = 1; instr1_enq_valid = 1;
      wb1_valid = 1; wb1_robidx = 6'd1;
      #1;
      checks++; if (commit0_valid !== 1'b0) begin errors++;
         $display("FAIL fl_cv got %b want 0", commit0_valid); end
      step();
      clr_in();
      #1;
      checks++; if (counter !== 7'd0) begin errors++;
         $display("FAIL fl_cnt got %0d want 0", counter); end
      checks++; if (enq_robidx !== 6'd0 || enq_robidx_flag !== 1'b0)
      begin errors++;
         $display("FAIL fl_tail got %0d/%b want 0/0",
                  enq_robidx, enq_robidx_flag); end
      checks++; if (commit0_valid !== 1'b0) begin errors++;
         $display("FAIL fl_after got %b want 0", commit0_valid); end
   endtask

   task automatic test_async_reset();
      do_reset();
      enq_cycle(1'b1);
      enq_cycle(1'b1);
      reset_n = 0;
      #2;
      checks++; if (counter !== 7'd0) begin errors++;
         $display("FAIL ar_cnt got %0d want 0", counter); end
      checks++; if (enq_robidx !== 6'd0 || enq_robidx_flag !== 1'b0)
      begin errors++;
         $display("FAIL ar_tail got %0d/%b want 0/0",
                  enq_robidx, enq_robidx_flag); end
      checks++; if (enq_ready !== 1'b1) begin errors++;
         $display("FAIL ar_rdy got %b want 1", enq_ready); end
      #1;
      reset_n = 1;
      step();
   endtask

   initial begin
      reset_n = 0;
      clr_in();
      step();
      test_reset();
      test_fill();
      test_drop();
      test_commit();
      test_back_to_back();
      test_wrap();
      test_flush();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rob_enq_commit.md
Name: rob_enq_commit

Overview:
- Reorder buffer that acts as the receiving end of the dispatch stage's ROB-enqueue interface.
- Allocates ROB indices and accepts up to two in-order instructions per cycle. Completion is marked by execution writeback.
- Retires up to two completed instructions per cycle, in program order, toward rename/freelist.
- Supplies `counter`, `enq_robidx` and `enq_robidx_flag` back to dispatch.

Parameters:
ROB_SIZE_LOG, 6, log2 of entry count (64 entries)
PREG_W, 6, physical register index width
LREG_W, 5, logical register index width
PC_W, 64, PC width

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush, clears all state
instr0_enq_valid  in  1  enqueue request, older slot
instr0_pc / instr0_lrd / instr0_prd / instr0_old_prd / instr0_need_to_wb  in  PC_W/LREG_W/PREG_W/PREG_W/1  payload
instr1_enq_valid  in  1  enqueue request, younger slot
instr1_pc / instr1_lrd / instr1_prd / instr1_old_prd / instr1_need_to_wb  in  same widths  payload
enq_ready  out  1  at least two free entries
counter  out  ROB_SIZE_LOG+1  occupied entries
enq_robidx_flag  out  1  wrap flag of tail
enq_robidx  out  ROB_SIZE_LOG  tail index, granted to instr0
wb0_valid / wb1_valid  in  1  completion strobes
wb0_robidx / wb1_robidx  in  ROB_SIZE_LOG  completing entry
commit0_valid / commit1_valid  out  1  retire strobes, older / younger
commit0_pc/lrd/prd/old_prd/need_to_wb, commit1_* (same)  out  as payload  retiring entry fields

Behaviour:
- Storage: 2^ROB_SIZE_LOG entries. Each holds the payload plus a complete bit.
- Pointers: head and tail are ROB_SIZE_LOG+1 bits each; the MSB is the wrap flag. `enq_robidx`/`enq_robidx_flag` are the tail's low bits and MSB.
- Reset (async, reset_n=0):
  - head, tail and counter = 0; all complete bits = 0.
  - Outputs: enq_ready=1, commit*_valid=0.
- `enq_ready` is combinational: `counter <= SIZE-2`.
- Enqueue accepted at the clock edge when `enq_ready & instrX_enq_valid`:
  - instr0 is written at tail.
  - instr1 is written at tail+1 and is legal only together with instr0. An instr1 without instr0 is dropped.
  - Tail advances by 0, 1 or 2, with modular wrap; the flag toggles when the index crosses SIZE-1 -> 0.
  - Complete bit of each new entry is cleared.
- Writeback: `wbX_valid` sets the complete bit at `wbX_robidx` at the clock edge.
  - Both ports may hit different entries in one cycle.
  - Writeback to an unallocated index is a protocol error; the design does not check it.
- Commit (combinational outputs from registered state; 0 added latency after completion is registered):
  - `commit0_valid = (counter>=1) & complete[head]`.
  - `commit1_valid = commit0_valid & (counter>=2) & complete[head+1]`.
  - Payload is driven from the head / head+1 entries.
  - Head advances by the number committed; the complete bits of committed entries are cleared.
- Earliest retirement: a writeback in cycle N allows commit in cycle N+1.
- Counter: `counter_next = counter + enq_n - commit_n`. Simultaneous enqueue and commit are both honoured.
- Flush (synchronous):
  - In the flush cycle: commit*_valid forced to 0; enqueue and writeback ignored.
  - At the next edge: head, tail and counter = 0, flags = 0, all complete bits = 0.
- Full case: counter = SIZE, enq_ready=0, head/tail indices equal with differing flags. Empty case: counter=0, indices and flags equal.
- Reset asserted mid-operation clears everything immediately, regardless of clock.

Test Plan:
- Reset release -> counter=0, enq_robidx=0, enq_robidx_flag=0, enq_ready=1, commit0/1_valid=0.
- Dual enqueue every cycle for 31 cycles -> counter=62, enq_ready still 1. One further dual enqueue -> counter=64, enq_ready=0, enq_robidx=0, enq_robidx_flag=1. A further valid request is not accepted (counter stays 64).
- Enqueue entries 0..3 (prd=10..13), then wb robidx 1, then wb robidx 0 -> no commit while entry 0 is incomplete. The cycle after wb 0: commit0_valid=1 with prd=10, commit1_valid=1 with prd=11. Next cycle counter=2 and no commit.
- Counter=10 with head/head+1 complete, plus dual enqueue in the same cycle -> 2 commits and 2 enqueues, counter stays 10, head +2, tail +2.
- Tail at 63: enqueue instr0+instr1 -> entries 63 and 0 written, enq_robidx=1, flag toggles 0->1. Completing and committing them wraps head likewise.
- Flush with counter=7 plus concurrent enqueue and wb -> commit valids 0 in that cycle; next cycle counter=0, enq_robidx=0, flag=0. Async reset pulse mid-stream -> same zero state without a clock edge.
